// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic light monitor: light bus
// encodings, the 3-bit tracked phase enumeration, FSM states and default
// dwell lengths.
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    localparam int DEFAULT_GREEN_DWELL  = 8;
    localparam int DEFAULT_YELLOW_DWELL = 4;

    localparam logic [3:0] DWELL_MAX = 4'd15;

    typedef enum logic [2:0] {
        PH_N_GREEN  = 3'd0,
        PH_N_YELLOW = 3'd1,
        PH_S_GREEN  = 3'd2,
        PH_S_YELLOW = 3'd3,
        PH_E_GREEN  = 3'd4,
        PH_E_YELLOW = 3'd5,
        PH_W_GREEN  = 3'd6,
        PH_W_YELLOW = 3'd7
    } phase_e;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } mon_state_e;

    // Successor in the fixed rotation; W-yellow wraps to N-green.
    function automatic phase_e next_phase(input phase_e p);
        return phase_e'(p + 3'd1);
    endfunction

endpackage

// File: rtl/light_decode.sv
// Decodes one 3-bit light bus into its colour flags. valid is set only for
// the three one-hot colour codes; every other pattern is an encoding error.
module light_decode
    import traffic_pkg::*;
(
    input  logic [2:0] lights,
    output logic       valid,
    output logic       is_red,
    output logic       is_yellow,
    output logic       is_green
);

    assign is_green  = (lights == LIGHT_GREEN);
    assign is_yellow = (lights == LIGHT_YELLOW);
    assign is_red    = (lights == LIGHT_RED);
    assign valid     = is_green | is_yellow | is_red;

endmodule

// File: rtl/traffic_monitor.sv
// Traffic light sequence monitor. Watches the four approach light buses,
// tracks the current phase and its dwell, and pulses a fault flag when the
// lights are mis-encoded, conflicting, out of sequence or mistimed.
// Optional feature macro: TRAFFIC_MON_TIMING_CHECK_EN enables dwell timing
// faults; without it fault_timing stays 0 while dwell_count still counts.
//
// state | meaning
// SYNC  | acquiring: phase loaded, waiting for first legal phase change
// TRACK | locked: every phase change and dwell length is checked
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_DWELL  = DEFAULT_GREEN_DWELL,
    parameter int YELLOW_DWELL = DEFAULT_YELLOW_DWELL
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       enable_L,
    input  logic [2:0] Main_North_Lights,
    input  logic [2:0] Main_South_Lights,
    input  logic [2:0] Local_East_Lights,
    input  logic [2:0] Local_West_Lights,
    output logic [2:0] phase,
    output logic       locked,
    output logic [3:0] dwell_count,
    output logic       fault_encoding,
    output logic       fault_conflict,
    output logic       fault_sequence,
    output logic       fault_timing,
    output logic       fault_sticky
);

`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    localparam bit TIMING_EN = 1'b1;
`else
    localparam bit TIMING_EN = 1'b0;
`endif

    localparam logic [3:0] GREEN_LIMIT  = 4'(GREEN_DWELL);
    localparam logic [3:0] YELLOW_LIMIT = 4'(YELLOW_DWELL);

    // Even phases are green, odd phases are yellow.
    function automatic logic [3:0] dwell_limit(input phase_e p);
        return p[0] ? YELLOW_LIMIT : GREEN_LIMIT;
    endfunction

    logic [3:0] bus_valid, bus_red, bus_yellow, bus_green;

    light_decode u_dec_north (
        .lights(Main_North_Lights), .valid(bus_valid[0]), .is_red(bus_red[0]),
        .is_yellow(bus_yellow[0]), .is_green(bus_green[0])
    );
    light_decode u_dec_south (
        .lights(Main_South_Lights), .valid(bus_valid[1]), .is_red(bus_red[1]),
        .is_yellow(bus_yellow[1]), .is_green(bus_green[1])
    );
    light_decode u_dec_east (
        .lights(Local_East_Lights), .valid(bus_valid[2]), .is_red(bus_red[2]),
        .is_yellow(bus_yellow[2]), .is_green(bus_green[2])
    );
    light_decode u_dec_west (
        .lights(Local_West_Lights), .valid(bus_valid[3]), .is_red(bus_red[3]),
        .is_yellow(bus_yellow[3]), .is_green(bus_green[3])
    );

    mon_state_e state_q, state_d;
    phase_e     phase_q, phase_d, samp_phase;
    logic [3:0] dwell_q, dwell_d, dwell_start, dwell_inc;
    logic       have_q, have_d;
    logic [2:0] red_cnt;
    logic       enc_ok;
    logic       f_enc_d, f_con_d, f_seq_d, f_tim_d;

    assign enc_ok      = &bus_valid;
    assign dwell_start = {3'b000, enable_L};
    assign dwell_inc   = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 4'd1;

    // Count red buses and derive the phase from the one lit bus (bus index, colour).
    always_comb begin
        red_cnt    = '0;
        samp_phase = PH_N_GREEN;
        for (int i = 0; i < 4; i++) begin
            red_cnt = red_cnt + 3'(bus_red[i]);
            if (bus_green[i] || bus_yellow[i])
                samp_phase = phase_e'({2'(i), bus_yellow[i]});
        end
    end

    // Next-state and fault decision; earlier branches take precedence.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dwell_d = dwell_q;
        have_d  = have_q;
        f_enc_d = 1'b0;
        f_con_d = 1'b0;
        f_seq_d = 1'b0;
        f_tim_d = 1'b0;
        if (!enc_ok) begin
            f_enc_d = 1'b1;
            state_d = ST_SYNC;
        end else if (red_cnt != 3'd3) begin
            f_con_d = 1'b1;
            state_d = ST_SYNC;
        end else if (!have_q) begin
            phase_d = samp_phase;
            dwell_d = dwell_start;
            have_d  = 1'b1;
        end else if (samp_phase == phase_q) begin
            if (enable_L) dwell_d = dwell_inc;
            // Stuck phase: flag on the sample that would overrun the dwell.
            // Dropping to SYNC makes this fire only once per phase.
            if (TIMING_EN && state_q == ST_TRACK && enable_L &&
                dwell_q == dwell_limit(phase_q)) begin
                f_tim_d = 1'b1;
                state_d = ST_SYNC;
            end
        end else begin
            phase_d = samp_phase;
            dwell_d = dwell_start;
            if (samp_phase != next_phase(phase_q)) begin
                f_seq_d = 1'b1;
                state_d = ST_SYNC;
            end else if (TIMING_EN && state_q == ST_TRACK &&
                         dwell_q != dwell_limit(phase_q)) begin
                f_tim_d = 1'b1;
                state_d = ST_SYNC;
            end else begin
                state_d = ST_TRACK;
            end
        end
    end

    // State, tracking and fault output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q        <= ST_SYNC;
            phase_q        <= PH_N_GREEN;
            dwell_q        <= '0;
            have_q         <= 1'b0;
            locked         <= 1'b0;
            fault_encoding <= 1'b0;
            fault_conflict <= 1'b0;
            fault_sequence <= 1'b0;
            fault_timing   <= 1'b0;
            fault_sticky   <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            dwell_q        <= dwell_d;
            have_q         <= have_d;
            locked         <= (state_d == ST_TRACK);
            fault_encoding <= f_enc_d;
            fault_conflict <= f_con_d;
            fault_sequence <= f_seq_d;
            fault_timing   <= f_tim_d;
            fault_sticky   <= fault_sticky | f_enc_d | f_con_d | f_seq_d | f_tim_d;
        end
    end

    assign phase       = phase_q;
    assign dwell_count = dwell_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Testbench for traffic_monitor: a behavioural light controller drives the
// buses with random enables, and a reference model of the monitoring rules
// predicts every output each cycle. Directed glitches inject conflict,
// encoding, timing and sequence faults plus a mid-phase reset.
module tb_traffic_monitor;
    import traffic_pkg::*;

`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    localparam bit TIMING_ON = 1'b1;
`else
    localparam bit TIMING_ON = 1'b0;
`endif
    localparam int GD = 8;
    localparam int YD = 4;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       enable_L = 1'b0;
    logic [2:0] mn = LIGHT_RED, ms = LIGHT_RED, le = LIGHT_RED, lw = LIGHT_RED;
    logic [2:0] phase;
    logic       locked;
    logic [3:0] dwell_count;
    logic       fault_encoding, fault_conflict, fault_sequence, fault_timing, fault_sticky;

    always #5 clk = ~clk;

    traffic_monitor #(.GREEN_DWELL(GD), .YELLOW_DWELL(YD)) dut (
        .clk(clk), .rst_a(rst_a), .enable_L(enable_L),
        .Main_North_Lights(mn), .Main_South_Lights(ms),
        .Local_East_Lights(le), .Local_West_Lights(lw),
        .phase(phase), .locked(locked), .dwell_count(dwell_count),
        .fault_encoding(fault_encoding), .fault_conflict(fault_conflict),
        .fault_sequence(fault_sequence), .fault_timing(fault_timing),
        .fault_sticky(fault_sticky)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Controller: shows phase ctl_phase for exactly limit enabled samples.
    int ctl_phase = 0;
    int ctl_cnt   = 0;
    bit ctl_freeze = 1'b0;

    // Reference model state.
    bit m_have, m_locked, m_fe, m_fc, m_fs, m_ft, m_sticky;
    int m_phase, m_dwell;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int limit_of(input int ph);
        return (ph % 2 == 1) ? YD : GD;
    endfunction

    function automatic logic [2:0] lamp(input int ph, input int bus);
        if (bus == ph / 2) return (ph % 2 == 1) ? LIGHT_YELLOW : LIGHT_GREEN;
        return LIGHT_RED;
    endfunction

    function automatic bit legal(input logic [2:0] v);
        return (v == LIGHT_GREEN) || (v == LIGHT_YELLOW) || (v == LIGHT_RED);
    endfunction

    task automatic model_step(input logic [2:0] b0, input logic [2:0] b1,
                              input logic [2:0] b2, input logic [2:0] b3,
                              input logic en, input logic rst);
        logic [2:0] b[4];
        int n_legal, n_lit, s_phase;
        bit changed, seq_ok;
        b = '{b0, b1, b2, b3};
        {m_fe, m_fc, m_fs, m_ft} = 4'b0000;
        if (rst) begin
            m_have = 0; m_locked = 0; m_sticky = 0; m_phase = 0; m_dwell = 0;
            return;
        end
        n_legal = 0; n_lit = 0; s_phase = 0; changed = 0; seq_ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (legal(b[i])) n_legal++;
            if (b[i] != LIGHT_RED) begin
                n_lit++;
                s_phase = 2 * i + ((b[i] == LIGHT_YELLOW) ? 1 : 0);
            end
        end
        if (n_legal != 4) m_fe = 1;
        else if (n_lit != 1) m_fc = 1;
        else if (!m_have) begin
            m_have = 1; m_phase = s_phase; m_dwell = en ? 1 : 0;
        end else if (s_phase == m_phase) begin
            if (TIMING_ON && m_locked && en && m_dwell + 1 > limit_of(m_phase)) m_ft = 1;
            if (en && m_dwell < 15) m_dwell++;
        end else begin
            changed = 1;
            seq_ok  = (s_phase == (m_phase + 1) % 8);
            if (!seq_ok) m_fs = 1;
            else if (TIMING_ON && m_locked && m_dwell != limit_of(m_phase)) m_ft = 1;
            m_phase = s_phase;
            m_dwell = en ? 1 : 0;
        end
        if (m_fe || m_fc || m_fs || m_ft) m_locked = 0;
        else if (changed) m_locked = 1;
        m_sticky = m_sticky | m_fe | m_fc | m_fs | m_ft;
    endtask

    task automatic compare_all();
        check_eq("phase", int'(phase), m_phase);
        check_eq("locked", int'(locked), int'(m_locked));
        check_eq("dwell_count", int'(dwell_count), m_dwell);
        check_eq("fault_encoding", int'(fault_encoding), int'(m_fe));
        check_eq("fault_conflict", int'(fault_conflict), int'(m_fc));
        check_eq("fault_sequence", int'(fault_sequence), int'(m_fs));
        check_eq("fault_timing", int'(fault_timing), int'(m_ft));
        check_eq("fault_sticky", int'(fault_sticky), int'(m_sticky));
    endtask

    // One clock: drive lights (optionally glitching one bus), then compare.
    task automatic cycle(input logic en, input logic rst, input int gbus, input logic [2:0] gval);
        logic [2:0] b[4];
        for (int i = 0; i < 4; i++) b[i] = lamp(ctl_phase, i);
        if (gbus >= 0 && gbus < 4) b[gbus] = gval;
        mn = b[0]; ms = b[1]; le = b[2]; lw = b[3];
        enable_L = en; rst_a = rst;
        @(posedge clk);
        model_step(b[0], b[1], b[2], b[3], en, rst);
        if (rst) begin
            ctl_phase = 0; ctl_cnt = 0;
        end else if (gbus < 0 && !ctl_freeze && en) begin
            if (ctl_cnt == limit_of(ctl_phase) - 1) begin
                ctl_phase = (ctl_phase + 1) % 8;
                ctl_cnt   = 0;
            end else begin
                ctl_cnt++;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic run(input int n, input bit rand_en);
        for (int k = 0; k < n; k++)
            cycle(rand_en ? logic'($urandom_range(0, 1)) : 1'b1, 1'b0, -1, LIGHT_RED);
    endtask

    initial begin
        int max_g, max_y;

        // Reset state
        cycle(1'b1, 1'b1, -1, LIGHT_RED);
        cycle(1'b1, 1'b1, -1, LIGHT_RED);
        check_eq("reset_phase", int'(phase), 0);
        check_eq("reset_locked", int'(locked), 0);
        check_eq("reset_dwell", int'(dwell_count), 0);
        check_eq("reset_sticky", int'(fault_sticky), 0);

        // Continuous enable: locks early, full dwells, no faults
        max_g = 0; max_y = 0;
        for (int k = 0; k < 200; k++) begin
            cycle(1'b1, 1'b0, -1, LIGHT_RED);
            if (phase[0]) max_y = (int'(dwell_count) > max_y) ? int'(dwell_count) : max_y;
            else          max_g = (int'(dwell_count) > max_g) ? int'(dwell_count) : max_g;
            if (k == 12) check_eq("locked_by_2nd_transition", int'(locked), 1);
        end
        check_eq("max_green_dwell", max_g, GD);
        check_eq("max_yellow_dwell", max_y, YD);
        check_eq("locked_after_200", int'(locked), 1);
        check_eq("no_fault_const_en", int'(fault_sticky), 0);

        // Random 50% enable: no faults, dwell holds on disabled samples
        run(300, 1'b1);
        check_eq("no_fault_rand_en", int'(fault_sticky), 0);

        // Conflict: East green while North green
        cycle(1'b1, 1'b1, -1, LIGHT_RED);
        run(48 + 3, 1'b0);
        check_eq("pre_conflict_locked", int'(locked), 1);
        cycle(1'b1, 1'b0, 2, LIGHT_GREEN);
        check_eq("conflict_pulse", int'(fault_conflict), 1);
        check_eq("conflict_not_enc", int'(fault_encoding), 0);
        check_eq("conflict_unlock", int'(locked), 0);
        check_eq("conflict_sticky", int'(fault_sticky), 1);
        cycle(1'b1, 1'b0, -1, LIGHT_RED);
        check_eq("conflict_one_cycle", int'(fault_conflict), 0);

        // Encoding: South bus 011
        run(5, 1'b1);
        cycle(1'b1, 1'b0, 1, 3'b011);
        check_eq("encoding_pulse", int'(fault_encoding), 1);
        check_eq("encoding_not_conflict", int'(fault_conflict), 0);
        run(20, 1'b1);

        // Stuck N-green for 9 enabled samples after locking
        cycle(1'b1, 1'b1, -1, LIGHT_RED);
        run(48, 1'b0);
        ctl_freeze = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cycle(1'b1, 1'b0, -1, LIGHT_RED);
            if (k == 7) check_eq("stuck_8th_ok", int'(fault_timing), 0);
            if (k == 8) check_eq("stuck_9th_timing", int'(fault_timing), int'(TIMING_ON));
        end
        run(4, 1'b0);
        ctl_freeze = 1'b0;

        // Sequence jump N-yellow -> E-green, then reset mid-phase
        cycle(1'b1, 1'b1, -1, LIGHT_RED);
        run(56 + 2, 1'b0);
        ctl_phase = 4; ctl_cnt = 0;
        cycle(1'b1, 1'b0, -1, LIGHT_RED);
        check_eq("jump_sequence", int'(fault_sequence), 1);
        check_eq("jump_not_timing", int'(fault_timing), 0);
        check_eq("jump_unlock", int'(locked), 0);
        run(3, 1'b0);
        cycle(1'b1, 1'b1, -1, LIGHT_RED);
        check_eq("midrst_phase", int'(phase), 0);
        check_eq("midrst_dwell", int'(dwell_count), 0);
        check_eq("midrst_locked", int'(locked), 0);
        check_eq("midrst_sticky", int'(fault_sticky), 0);
        check_eq("midrst_faults", int'({fault_encoding, fault_conflict, fault_sequence, fault_timing}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
